// File: rtl/load_use_scoreboard_if.sv
// load_use_scoreboard_if: ID-stage hazard query bundle between pipeline control and the load-use scoreboard
interface load_use_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW = 5
);
  logic id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic id_rs1_used;
  logic id_rs2_used;
  logic [AW-1:0] id_rd;
  logic id_rd_we;
  logic id_is_load;
  logic flush;
  logic stall;
  logic [NREG-1:0] busy_vec;
  logic [31:0] stall_cycles;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_is_load, flush,
    input stall, busy_vec, stall_cycles
  );
  modport slave (
    input id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_is_load, flush,
    output stall, busy_vec, stall_cycles
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: per-register load countdowns driving the ID-stage stall; HAZARD_STALL_CNT_EN adds a saturating stall-cycle counter
module load_use_scoreboard #(
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int LOAD_LAT = 1,
  parameter int CW = 3
) (
  input logic clk,
  input logic rst_n,
  load_use_scoreboard_if.slave bus
);
  logic [CW-1:0] cnt [NREG];
  logic [NREG-1:0] busy;
  logic [2**AW-1:0] busy_pad;
  logic hit_1, hit_2, stall, issue;
  for (genvar i = 0; i < NREG; i++) begin : g_busy
    assign busy[i] = cnt[i] != '0;
  end
  // zero-extend so indices >= NREG read as not busy
  assign busy_pad = (2**AW)'(busy);
  assign hit_1 = bus.id_rs1_used && bus.id_rs1 != '0 && busy_pad[bus.id_rs1];
  assign hit_2 = bus.id_rs2_used && bus.id_rs2 != '0 && busy_pad[bus.id_rs2];
  assign stall = bus.id_valid && !bus.flush && (hit_1 || hit_2);
  assign issue = bus.id_valid && !stall && !bus.flush && bus.id_rd_we && bus.id_rd != '0;
  assign bus.stall = stall;
  assign bus.busy_vec = busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    else
      for (int r = 0; r < NREG; r++)
        cnt[r] <= (issue && bus.id_rd == AW'(r)) ? (bus.id_is_load ? CW'(LOAD_LAT) : '0)
                : (cnt[r] != '0 ? cnt[r] - CW'(1) : '0);
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: random and directed checks of two scoreboards (LOAD_LAT 1/NREG 32, LOAD_LAT 3/NREG 24)
module tb_load_use_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic v, u1, u2, we, ld, fl;
  logic [4:0] rs1, rs2, rd;
  load_use_scoreboard_if #(.NREG(32), .AW(5)) ifa ();
  load_use_scoreboard_if #(.NREG(24), .AW(5)) ifb ();
  assign ifa.id_valid = v, ifa.id_rs1 = rs1, ifa.id_rs2 = rs2, ifa.id_rs1_used = u1, ifa.id_rs2_used = u2,
         ifa.id_rd = rd, ifa.id_rd_we = we, ifa.id_is_load = ld, ifa.flush = fl;
  assign ifb.id_valid = v, ifb.id_rs1 = rs1, ifb.id_rs2 = rs2, ifb.id_rs1_used = u1, ifb.id_rs2_used = u2,
         ifb.id_rd = rd, ifb.id_rd_we = we, ifb.id_is_load = ld, ifb.flush = fl;
  load_use_scoreboard #(.NREG(32), .AW(5), .LOAD_LAT(1), .CW(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  load_use_scoreboard #(.NREG(24), .AW(5), .LOAD_LAT(3), .CW(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat [2] = '{1, 3};
  int nreg [2] = '{32, 24};
  int iss [2][32];
  bit mld [2][32];
  int sc [2];
  // a register is pending while its last writer was a load issued fewer than LOAD_LAT edges ago
  function automatic bit mbusy(int k, int r);
    return r != 0 && r < nreg[k] && mld[k][r] && (cyc - iss[k][r]) < lat[k];
  endfunction
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask
  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      sc[k] = 0;
      for (int r = 0; r < 32; r++) begin
        mld[k][r] = 1'b0;
        iss[k][r] = 0;
      end
    end
  endtask
  task automatic compare();
    logic [31:0] st [2], bv [2], scd [2], eb;
    bit es;
    st[0] = 32'(ifa.stall);
    st[1] = 32'(ifb.stall);
    bv[0] = ifa.busy_vec;
    bv[1] = {8'b0, ifb.busy_vec};
    scd[0] = ifa.stall_cycles;
    scd[1] = ifb.stall_cycles;
    for (int k = 0; k < 2; k++) begin
      es = v && !fl && ((u1 && mbusy(k, int'(rs1))) || (u2 && mbusy(k, int'(rs2))));
      eb = '0;
      for (int r = 0; r < 32; r++) eb[r] = mbusy(k, r);
      chk($sformatf("stall%0d", k), st[k], 32'(es));
      chk($sformatf("busy_vec%0d", k), bv[k], eb);
`ifdef HAZARD_STALL_CNT_EN
      chk($sformatf("stall_cycles%0d", k), scd[k], sc[k]);
`else
      chk($sformatf("stall_cycles%0d", k), scd[k], 32'd0);
`endif
      if (es) sc[k]++;
      if (v && !es && !fl && we && rd != 0 && int'(rd) < nreg[k]) begin
        iss[k][rd] = cyc + 1;
        mld[k][rd] = ld;
      end
    end
    cyc++;
  endtask
  task automatic step(bit vv, logic [4:0] a, bit au, logic [4:0] b, bit bu, logic [4:0] d, bit dw, bit dl, bit f);
    @(posedge clk);
    #1;
    v = vv; rs1 = a; u1 = au; rs2 = b; u2 = bu; rd = d; we = dw; ld = dl; fl = f;
    @(negedge clk);
    compare();
  endtask
  task automatic nops(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
  endfunction
  initial begin
    {v, u1, u2, we, ld, fl} = '0;
    {rs1, rs2, rd} = '0;
    mreset();
    #2;
    chk("rst_stall_a", 32'(ifa.stall), 0);
    chk("rst_stall_b", 32'(ifb.stall), 0);
    chk("rst_busy_a", ifa.busy_vec, 0);
    chk("rst_sc_b", ifb.stall_cycles, 0);
    #10 rst_n = 1'b1;
    // lw x5 then add x6,x5,x1 held in ID
    step(1, 0, 0, 0, 0, 5, 1, 1, 0);
    chk("t1_lw_a", 32'(ifa.stall), 0);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("t1_c1_a", 32'(ifa.stall), 1);
    chk("t1_c1_busy5", 32'(ifa.busy_vec[5]), 1);
    chk("t1_c1_b", 32'(ifb.stall), 1);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("t1_c2_a", 32'(ifa.stall), 0);
    chk("t1_c2_busy5", 32'(ifa.busy_vec[5]), 0);
    chk("t1_c2_b", 32'(ifb.stall), 1);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("t1_c3_b", 32'(ifb.stall), 1);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("t1_c4_b", 32'(ifb.stall), 0);
    // one independent instruction shortens the stall
    step(1, 0, 0, 0, 0, 7, 1, 1, 0);
    step(1, 1, 1, 2, 1, 8, 1, 0, 0);
    step(1, 7, 1, 0, 0, 9, 1, 0, 0);
    chk("t2_c1_b", 32'(ifb.stall), 1);
    chk("t2_c1_a", 32'(ifa.stall), 0);
    step(1, 7, 1, 0, 0, 9, 1, 0, 0);
    chk("t2_c2_b", 32'(ifb.stall), 1);
    step(1, 7, 1, 0, 0, 9, 1, 0, 0);
    chk("t2_c3_b", 32'(ifb.stall), 0);
    // WAW: younger ALU write clears the pending load
    step(1, 0, 0, 0, 0, 9, 1, 1, 0);
    step(1, 0, 1, 0, 0, 9, 1, 0, 0);
    chk("t3_addi_b", 32'(ifb.stall), 0);
    step(1, 9, 1, 0, 0, 10, 1, 0, 0);
    chk("t3_reader_b", 32'(ifb.stall), 0);
    chk("t3_reader_a", 32'(ifa.stall), 0);
    // x0 and unused operands
    step(1, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 1, 11, 1, 0, 0);
    chk("t4_x0_b", 32'(ifb.stall), 0);
    step(1, 0, 0, 0, 0, 5, 1, 1, 0);
    step(1, 1, 1, 5, 0, 11, 1, 0, 0);
    chk("t4_unused_b", 32'(ifb.stall), 0);
    chk("t4_unused_a", 32'(ifa.stall), 0);
    step(1, 5, 1, 5, 1, 12, 1, 0, 0);
    chk("t4_double_b", 32'(ifb.stall), 1);
    nops(4);
    // flush during a stall
    step(1, 0, 0, 0, 0, 7, 1, 1, 0);
    step(1, 7, 1, 0, 0, 12, 1, 0, 1);
    chk("t5_flush_a", 32'(ifa.stall), 0);
    chk("t5_flush_b", 32'(ifb.stall), 0);
    chk("t5_flush_busy7", 32'(ifb.busy_vec[7]), 1);
    step(1, 7, 1, 0, 0, 12, 1, 0, 0);
    chk("t5_after_b", 32'(ifb.stall), 1);
    step(1, 7, 1, 0, 0, 12, 1, 0, 0);
    step(1, 7, 1, 0, 0, 12, 1, 0, 0);
    chk("t5_end_b", 32'(ifb.stall), 0);
    chk("t5_end_busy7", 32'(ifb.busy_vec[7]), 0);
    // index beyond NREG on the 24-register instance
    step(1, 0, 0, 0, 0, 25, 1, 1, 0);
    step(1, 25, 1, 0, 0, 13, 1, 0, 0);
    chk("t7_hi_a", 32'(ifa.stall), 1);
    chk("t7_hi_b", 32'(ifb.stall), 0);
    nops(4);
    // asynchronous reset mid-stall
    step(1, 0, 0, 0, 0, 7, 1, 1, 0);
    step(1, 7, 1, 0, 0, 14, 1, 0, 0);
    chk("t6_pre_b", 32'(ifb.stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_stall_b", 32'(ifb.stall), 0);
    chk("t6_busy_b", {8'b0, ifb.busy_vec}, 0);
    chk("t6_busy_a", ifa.busy_vec, 0);
    chk("t6_sc_b", ifb.stall_cycles, 0);
    mreset();
    #3 rst_n = 1'b1;
    repeat (1500)
      step($urandom_range(0, 7) != 0, rreg(), 1'($urandom_range(0, 1)), rreg(), 1'($urandom_range(0, 1)),
           rreg(), $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
